packet_validator: RTL and testbench

//  Ingress stage directly upstream of a que_slot. Takes a raw Ethernet frame byte stream (preamble/SFD

---
 rtl/packet_validator_pkg.sv | 31 +++
 rtl/crc32_d8_update.sv | 16 +
 rtl/packet_validator.sv | 158 +++++++++++++++
 tb/tb_packet_validator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_validator_pkg.sv
// rtl/packet_validator_pkg.sv - shared types, CRC-32 constants and byte-wise CRC helper
// Contents:
//   state_type    : validator FSM states
//   CRC32_INIT    : CRC register start value
//   CRC32_POLY    : reflected CRC-32 polynomial
//   CRC32_RESIDUE : register value after a frame whose FCS is correct
//   crc32_d8      : advance a reflected CRC-32 register by one byte
package packet_validator_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_VERDICT = 2'd2,
    S_DISCARD = 2'd3
  } state_type;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  // LSB-first: the byte is folded into the low end, then eight shift/xor steps.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data_in);
    logic [31:0] c;
    c = crc ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8_update.sv
// rtl/crc32_d8_update.sv - combinational next-CRC for one input byte
// Ports:
//   crc      in  32  current CRC register
//   data_in  in   8  byte to fold in
//   crc_next out 32  CRC after the byte
module crc32_d8_update
  import packet_validator_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_next
);

  assign crc_next = crc32_d8(crc, data_in);

endmodule

// File: rtl/packet_validator.sv
// rtl/packet_validator.sv - Ethernet frame ingress check (CRC-32, length) in front of a que_slot
// Optional build macro: PACKET_VALIDATOR_STRIP_FCS_EN (hold back 4 bytes so the FCS is never forwarded)
// Ports:
//   clock         in   1  single clock, posedge
//   reset         in   1  synchronous, active-high
//   rx_data       in   8  frame byte
//   rx_data_valid in   1  high across one frame; a low cycle ends it
//   rx_error      in   1  PHY error, sampled on valid bytes
//   slot_ready    in   1  que_slot ready, sampled on the first byte
//   data          out  8  byte to que_slot
//   data_enable   out  1  data qualifier
//   good_packet   out  1  pulse: frame passed
//   bad_packet    out  1  pulse: frame failed, slot flushes
//   frame_dropped out  1  pulse: frame ignored, slot was not ready
module packet_validator
  import packet_validator_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_error,
  input  logic       slot_ready,
  output logic [7:0] data,
  output logic       data_enable,
  output logic       good_packet,
  output logic       bad_packet,
  output logic       frame_dropped
);

  localparam logic [10:0] MIN_COUNT = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_COUNT = 11'(MAX_FRAME_BYTES);

  state_type   state, next_state;
  logic        silent, next_silent;
  logic [31:0] crc, next_crc, crc_base, crc_update;
  logic [10:0] byte_count, next_count;
  logic        err, next_err;
  logic        start, forward, good_next, bad_next, dropped_next;
  logic [7:0]  out_byte;
  logic        out_enable;

  assign start    = (state == S_IDLE) && rx_data_valid && slot_ready;
  assign crc_base = start ? CRC32_INIT : crc;

  crc32_d8_update u_crc (
    .crc      (crc_base),
    .data_in  (rx_data),
    .crc_next (crc_update)
  );

  // The verdict is registered on the cycle rx_data_valid drops, so the pulse
  // lands in the one S_VERDICT cycle (L+2) and never overlaps data_enable.
  always_comb begin
    next_state   = state;
    next_silent  = silent;
    next_crc     = crc;
    next_count   = byte_count;
    next_err     = err;
    forward      = 1'b0;
    good_next    = 1'b0;
    bad_next     = 1'b0;
    dropped_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RECEIVE;
          forward    = 1'b1;
          next_crc   = crc_update;
          next_count = 11'd1;
          next_err   = rx_error;
        end else if (rx_data_valid) begin
          next_state   = S_DISCARD;
          next_silent  = 1'b1;
          dropped_next = 1'b1;
        end
      end
      S_RECEIVE: begin
        if (!rx_data_valid) begin
          next_state = S_VERDICT;
          if (!err && byte_count >= MIN_COUNT && crc == CRC32_RESIDUE) good_next = 1'b1;
          else bad_next = 1'b1;
        end else if (byte_count >= MAX_COUNT) begin
          // Oversize: cut the frame here; the verdict comes when it ends.
          next_state  = S_DISCARD;
          next_silent = 1'b0;
        end else begin
          forward    = 1'b1;
          next_crc   = crc_update;
          next_count = (byte_count == 11'h7FF) ? byte_count : byte_count + 11'd1;
          next_err   = err | rx_error;
        end
      end
      S_VERDICT: next_state = S_IDLE;
      S_DISCARD: begin
        if (!rx_data_valid) begin
          next_state  = S_IDLE;
          bad_next    = !silent;
          next_silent = 1'b1;
        end
      end
      default: next_state = S_DISCARD;
    endcase
  end

`ifdef PACKET_VALIDATOR_STRIP_FCS_EN
  // hold[31:24] is the oldest byte; it leaves only once four newer bytes
  // have arrived, so the trailing four (the FCS) are never emitted.
  logic [31:0] hold;
  logic [2:0]  fill;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= 32'h0;
      fill <= 3'd0;
    end else if (forward) begin
      hold <= start ? {24'h0, rx_data} : {hold[23:0], rx_data};
      fill <= start ? 3'd1 : ((fill == 3'd4) ? 3'd4 : fill + 3'd1);
    end
  end

  assign out_byte   = hold[31:24];
  assign out_enable = forward && !start && (fill == 3'd4);
`else
  assign out_byte   = rx_data;
  assign out_enable = forward;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_DISCARD;
      silent        <= 1'b1;
      crc           <= CRC32_INIT;
      byte_count    <= 11'd0;
      err           <= 1'b0;
      data          <= 8'h00;
      data_enable   <= 1'b0;
      good_packet   <= 1'b0;
      bad_packet    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state         <= next_state;
      silent        <= next_silent;
      crc           <= next_crc;
      byte_count    <= next_count;
      err           <= next_err;
      data          <= out_enable ? out_byte : 8'h00;
      data_enable   <= out_enable;
      good_packet   <= good_next;
      bad_packet    <= bad_next;
      frame_dropped <= dropped_next;
    end
  end

endmodule

// File: tb/tb_packet_validator.sv
// tb/tb_packet_validator.sv - self-checking bench for packet_validator
module tb_packet_validator;

  localparam int NCYC = 4096;
  localparam int MIN_B = 64;
  localparam int MAX_B = 1518;
`ifdef PACKET_VALIDATOR_STRIP_FCS_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       slot_ready = 1'b0;
  logic [7:0] data;
  logic       data_enable, good_packet, bad_packet, frame_dropped;

  packet_validator dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_error      (rx_error),
    .slot_ready    (slot_ready),
    .data          (data),
    .data_enable   (data_enable),
    .good_packet   (good_packet),
    .bad_packet    (bad_packet),
    .frame_dropped (frame_dropped)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected per-cycle outputs, filled by the frame model.
  bit         exp_de   [NCYC];
  logic [7:0] exp_data [NCYC];
  bit         exp_good [NCYC];
  bit         exp_bad  [NCYC];
  bit         exp_drop [NCYC];

  logic [7:0] frm [2048];

  int good_seen = 0, bad_seen = 0, de_seen = 0, drop_seen = 0;
  bit chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en && cyc < NCYC) begin
      check("data_enable", 32'(data_enable), 32'(exp_de[cyc]));
      check("good_packet", 32'(good_packet), 32'(exp_good[cyc]));
      check("bad_packet", 32'(bad_packet), 32'(exp_bad[cyc]));
      check("frame_dropped", 32'(frame_dropped), 32'(exp_drop[cyc]));
      if (exp_de[cyc]) check("data", 32'(data), 32'(exp_data[cyc]));
      if (data_enable === 1'b1) de_seen++;
      if (good_packet === 1'b1) good_seen++;
      if (bad_packet === 1'b1) bad_seen++;
      if (frame_dropped === 1'b1) drop_seen++;
    end
  end

  // Standard Ethernet FCS value over frm[first +: n], bit-serial.
  function automatic logic [31:0] fcs_of(input int first, input int n);
    logic [31:0] c;
    logic        mix;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        mix = c[0] ^ frm[first + i][b];
        c = c >> 1;
        if (mix) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input int n);
    if (n < 4) return 1'b0;
    return fcs_of(0, n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
  endfunction

  function automatic int build_frame(input int payload);
    logic [31:0] f;
    for (int i = 0; i < payload; i++) frm[i] = 8'(i);
    f = fcs_of(0, payload);
    frm[payload]   = f[7:0];
    frm[payload+1] = f[15:8];
    frm[payload+2] = f[23:16];
    frm[payload+3] = f[31:24];
    return payload + 4;
  endfunction

  function automatic void put(input int idx, input int kind, input logic [7:0] val);
    if (idx < 0 || idx >= NCYC) return;
    case (kind)
      0: begin exp_de[idx] = 1'b1; exp_data[idx] = val; end
      1: exp_good[idx] = 1'b1;
      2: exp_bad[idx] = 1'b1;
      default: exp_drop[idx] = 1'b1;
    endcase
  endfunction

  // First byte in cycle s; frame of n bytes; last byte L = s+n-1, verdict at L+2.
  function automatic void expect_frame(input int s, input int n, input bit ready,
                                       input int err_at, input int reset_at);
    int fwd;
    bit aborted, good;
    if (!ready) begin
      put(s + 1, 3, 8'h00);
      return;
    end
    aborted = (reset_at >= 0) && (reset_at < n);
    fwd = aborted ? reset_at : n;
    if (fwd > MAX_B) fwd = MAX_B;
    if (STRIP) begin
      for (int k = 0; k < fwd - 4; k++) put(s + k + 5, 0, frm[k]);
    end else begin
      for (int k = 0; k < fwd; k++) put(s + k + 1, 0, frm[k]);
    end
    if (!aborted) begin
      good = (n >= MIN_B) && (n <= MAX_B) && !(err_at >= 0 && err_at < n) && fcs_ok(n);
      put(s + n + 1, good ? 1 : 2, 8'h00);
    end
  endfunction

  task automatic send_frame(input int n, input bit ready, input int err_at,
                            input int reset_at, input int gap);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      if (k == 0) expect_frame(cyc, n, ready, err_at, reset_at);
      rx_data_valid = 1'b1;
      rx_data       = frm[k];
      rx_error      = (k == err_at);
      slot_ready    = (k == 0) ? ready : !ready;
      reset         = (reset_at >= 0) && (k == reset_at || k == reset_at + 1);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
      rx_data_valid = 1'b0;
      rx_error      = 1'b0;
      rx_data       = 8'h00;
      reset         = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clock); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, g0, b0, d0, p0;
    string s9;

    // Pin the model CRC: CRC-32 of "123456789" is CBF43926.
    s9 = "123456789";
    for (int i = 0; i < 9; i++) frm[i] = s9[i];
    check("model_crc_check_string", fcs_of(0, 9), 32'hCBF4_3926);

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    check("reset_data_enable", 32'(data_enable), 32'd0);
    check("reset_good", 32'(good_packet), 32'd0);
    check("reset_bad", 32'(bad_packet), 32'd0);
    check("reset_dropped", 32'(frame_dropped), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    reset = 1'b0;
    settle();

    // 1: good 64-byte frame
    n = build_frame(60);
    check("model_t1_good", 32'(fcs_ok(n)), 32'd1);
    g0 = good_seen; b0 = bad_seen; d0 = de_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t1_beats", de_seen - d0, STRIP ? 60 : 64);
    check("t1_good", good_seen - g0, 1);
    check("t1_bad", bad_seen - b0, 0);

    // 2: corrupted byte 10
    frm[10] = 8'hFF;
    check("model_t2_bad", 32'(fcs_ok(n)), 32'd0);
    g0 = good_seen; b0 = bad_seen; d0 = de_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t2_beats", de_seen - d0, STRIP ? 60 : 64);
    check("t2_good", good_seen - g0, 0);
    check("t2_bad", bad_seen - b0, 1);

    // 3: runt with valid CRC, then oversize
    n = build_frame(56);
    check("model_t3_runt_crc", 32'(fcs_ok(n)), 32'd1);
    b0 = bad_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t3_runt_bad", bad_seen - b0, 1);
    n = build_frame(1515);
    b0 = bad_seen; d0 = de_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t3_long_beats", de_seen - d0, STRIP ? 1514 : 1518);
    check("t3_long_bad", bad_seen - b0, 1);

    // 4: slot not ready, then accepted frame
    n = build_frame(96);
    g0 = good_seen; b0 = bad_seen; d0 = de_seen; p0 = drop_seen;
    send_frame(n, 1'b0, -1, -1, 2); settle();
    check("t4_dropped", drop_seen - p0, 1);
    check("t4_beats", de_seen - d0, 0);
    check("t4_verdicts", (good_seen - g0) + (bad_seen - b0), 0);
    n = build_frame(60);
    g0 = good_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t4_next_good", good_seen - g0, 1);

    // 5: rx_error on byte 30, then reset at byte 50
    n = build_frame(124);
    g0 = good_seen; b0 = bad_seen;
    send_frame(n, 1'b1, 30, -1, 2); settle();
    check("t5_err_bad", bad_seen - b0, 1);
    check("t5_err_good", good_seen - g0, 0);
    n = build_frame(96);
    g0 = good_seen; b0 = bad_seen; d0 = de_seen;
    send_frame(n, 1'b1, -1, 50, 2); settle();
    check("t5_reset_beats", de_seen - d0, STRIP ? 46 : 50);
    check("t5_reset_verdicts", (good_seen - g0) + (bad_seen - b0), 0);
    n = build_frame(60);
    g0 = good_seen;
    send_frame(n, 1'b1, -1, -1, 2); settle();
    check("t5_recover_good", good_seen - g0, 1);

    // 6: back-to-back good frames, 2-cycle gap
    n = build_frame(60);
    g0 = good_seen; b0 = bad_seen; d0 = de_seen;
    send_frame(n, 1'b1, -1, -1, 2);
    send_frame(n, 1'b1, -1, -1, 2);
    settle();
    check("t6_good", good_seen - g0, 2);
    check("t6_bad", bad_seen - b0, 0);
    check("t6_beats", de_seen - d0, STRIP ? 120 : 128);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
